g_evt_latch: RTL and testbench

Event-capture stage directly downstream of the g_3or combining gate. It takes the ORed request level Y of a g_3or as its asynchronous input and synchronizes it into the CK domain. It then glitch-filters the level and converts each qualified rising edge into a one-cycle pulse, a sticky pending flag, and a saturating event count. Software or control logic clears the captured state with ACK.

---
 rtl/g_evt_pkg.sv | 20 ++
 rtl/g_sync.sv | 20 ++
 rtl/g_evt_latch.sv | 148 ++++++++++++++
 tb/tb_g_evt_latch.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/g_evt_pkg.sv
// Shared types and limits for the g_evt event-capture macros.
package g_evt_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    QUAL_HI = 2'd1,
    HIGH    = 2'd2,
    QUAL_LO = 2'd3
  } filt_state_t;

  localparam int FILT_CW = 4;

  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;
  localparam int FILT_MIN  = 1;
  localparam int FILT_MAX  = 15;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

endpackage

// File: rtl/g_sync.sv
// Plain flop-chain synchronizer with asynchronous clear; output is the last stage.
module g_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CK,
  input  logic CD,
  input  logic i_d,
  output logic o_s
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) r_chain <= '0;
    else    r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_s = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/g_evt_latch.sv
// Event capture: synchronize A, glitch-filter it into Y, and latch each qualified
// rise as a pulse (P), sticky flag (Q), saturating count (N) and overrun (OVR).
module g_evt_latch
  import g_evt_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = 8
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             A,
  input  logic             ACK,
  output logic             Y,
  output logic             P,
  output logic             Q,
  output logic [CNT_W-1:0] N,
  output logic             OVR
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
    $error("g_evt_latch: SYNC_STAGES out of range");
  end
  if (FILT_LEN < FILT_MIN || FILT_LEN > FILT_MAX) begin : g_bad_filt
    $error("g_evt_latch: FILT_LEN out of range");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("g_evt_latch: CNT_W out of range");
  end

  localparam logic [FILT_CW-1:0] LP_CNT_ONE  = FILT_CW'(1);
  localparam logic [FILT_CW-1:0] LP_CNT_LAST = FILT_CW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0]   LP_N_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]   LP_N_MAX    = '1;

  logic               w_s;
  filt_state_t        r_state, w_state_nx;
  logic [FILT_CW-1:0] r_cnt, w_cnt_nx;
  logic               r_y, w_y_nx;
  logic               r_p, r_q, r_ovr;
  logic [CNT_W-1:0]   r_n;
  logic               w_rise;

  g_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .CK  (CK),
    .CD  (CD),
    .i_d (A),
    .o_s (w_s)
  );

  // cnt counts consecutive edges at which S disagrees with Y; FILT_LEN of them flips Y.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_y_nx     = r_y;
    unique case (r_state)
      LOW: begin
        if (w_s) begin
          if (FILT_LEN == 1) begin
            w_state_nx = HIGH;
            w_y_nx     = 1'b1;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = QUAL_HI;
            w_cnt_nx   = LP_CNT_ONE;
          end
        end
      end
      QUAL_HI: begin
        if (!w_s) begin
          w_state_nx = LOW;
          w_cnt_nx   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nx = HIGH;
          w_y_nx     = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + LP_CNT_ONE;
        end
      end
      HIGH: begin
        if (!w_s) begin
          if (FILT_LEN == 1) begin
            w_state_nx = LOW;
            w_y_nx     = 1'b0;
            w_cnt_nx   = '0;
          end else begin
            w_state_nx = QUAL_LO;
            w_cnt_nx   = LP_CNT_ONE;
          end
        end
      end
      QUAL_LO: begin
        if (w_s) begin
          w_state_nx = HIGH;
          w_cnt_nx   = '0;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_state_nx = LOW;
          w_y_nx     = 1'b0;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + LP_CNT_ONE;
        end
      end
      default: begin
        w_state_nx = LOW;
        w_cnt_nx   = '0;
        w_y_nx     = 1'b0;
      end
    endcase
  end

  assign w_rise = w_y_nx & ~r_y;

  always_ff @(posedge CK or posedge CD) begin
    if (CD) begin
      r_state <= LOW;
      r_cnt   <= '0;
      r_y     <= 1'b0;
      r_p     <= 1'b0;
      r_q     <= 1'b0;
      r_n     <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_y     <= w_y_nx;
      r_p     <= w_rise;
      // A rise coinciding with ACK starts a fresh capture rather than being lost.
      if (w_rise) begin
        r_q   <= 1'b1;
        r_n   <= ACK ? LP_N_ONE : ((r_n == LP_N_MAX) ? r_n : r_n + LP_N_ONE);
        r_ovr <= ACK ? 1'b0 : (r_ovr | r_q);
      end else if (ACK) begin
        r_q   <= 1'b0;
        r_n   <= '0;
        r_ovr <= 1'b0;
      end
    end
  end

  assign Y   = r_y;
  assign P   = r_p;
  assign Q   = r_q;
  assign N   = r_n;
  assign OVR = r_ovr;

endmodule

// File: tb/tb_g_evt_latch.sv
// Bench for g_evt_latch: two configurations driven in parallel against a run-length reference model.
module tb_g_evt_latch;

  logic       CK = 1'b0;
  logic       CD;
  logic       A;
  logic       ACK;
  logic       Y0, P0, Q0, OVR0;
  logic [7:0] N0;
  logic       Y1, P1, Q1, OVR1;
  logic [1:0] N1;

  int checks   = 0;
  int failures = 0;

  g_evt_latch #(.SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(8)) u_dut0 (
    .CK(CK), .CD(CD), .A(A), .ACK(ACK),
    .Y(Y0), .P(P0), .Q(Q0), .N(N0), .OVR(OVR0)
  );

  g_evt_latch #(.SYNC_STAGES(3), .FILT_LEN(1), .CNT_W(2)) u_dut1 (
    .CK(CK), .CD(CD), .A(A), .ACK(ACK),
    .Y(Y1), .P(P1), .Q(Q1), .N(N1), .OVR(OVR1)
  );

  always #5 CK = ~CK;

  // Reference model: Y flips once S has disagreed with it for FILT_LEN consecutive edges.
  int cfg_sync[2] = '{2, 3};
  int cfg_filt[2] = '{3, 1};
  int cfg_max[2]  = '{255, 3};
  bit m_h[2][4];
  bit m_y[2], m_p[2], m_q[2], m_ovr[2];
  int m_n[2], m_run[2];

  always @(posedge CK or posedge CD) begin
    for (int i = 0; i < 2; i++) begin
      if (CD) begin
        for (int k = 0; k < 4; k++) m_h[i][k] = 1'b0;
        m_y[i] = 0; m_p[i] = 0; m_q[i] = 0; m_ovr[i] = 0; m_n[i] = 0; m_run[i] = 0;
      end else begin : step
        bit s;
        bit rise;
        s    = m_h[i][cfg_sync[i]-1];
        rise = 1'b0;
        if (s != m_y[i]) begin
          m_run[i]++;
          if (m_run[i] >= cfg_filt[i]) begin
            m_y[i]   = s;
            m_run[i] = 0;
            rise     = s;
          end
        end else begin
          m_run[i] = 0;
        end
        m_p[i] = rise;
        if (rise) begin
          m_ovr[i] = ACK ? 1'b0 : (m_ovr[i] | m_q[i]);
          m_q[i]   = 1'b1;
          m_n[i]   = ACK ? 1 : ((m_n[i] < cfg_max[i]) ? m_n[i] + 1 : m_n[i]);
        end else if (ACK) begin
          m_q[i] = 0; m_n[i] = 0; m_ovr[i] = 0;
        end
        for (int k = 3; k > 0; k--) m_h[i][k] = m_h[i][k-1];
        m_h[i][0] = A;
      end
    end
  end

  wire [11:0] act0 = {Y0, P0, Q0, N0, OVR0};
  wire [11:0] act1 = {Y1, P1, Q1, 6'b0, N1, OVR1};

  function automatic logic [11:0] exp_vec(input int i);
    return {m_y[i], m_p[i], m_q[i], 8'(m_n[i]), m_ovr[i]};
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic settle();
    A = 1'b0; ACK = 1'b0;
    repeat (12) tick();
    ACK = 1'b1; tick();
    ACK = 1'b0; tick();
  endtask

  task automatic pulse(input int hi, input int lo);
    A = 1'b1; repeat (hi) tick();
    A = 1'b0; repeat (lo) tick();
  endtask

  task automatic test_reset();
    int e0, e1;
    logic p_at, q_at;
    logic [7:0] n_at;
    CD = 1'b1; A = 1'b1; ACK = 1'b0;
    repeat (3) tick();
    checks++;
    if (act0 !== 12'h000) begin failures++; $display("FAIL reset0 got=%h exp=000", act0); end
    checks++;
    if (act1 !== 12'h000) begin failures++; $display("FAIL reset1 got=%h exp=000", act1); end
    CD = 1'b0;
    e0 = 0; e1 = 0; p_at = 0; q_at = 0; n_at = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e0 == 0 && Y0 === 1'b1) begin e0 = e; p_at = P0; q_at = Q0; n_at = N0; end
      if (e1 == 0 && Y1 === 1'b1) e1 = e;
      checks++;
      if (act0 !== exp_vec(0)) begin failures++; $display("FAIL reset_seq0 e=%0d got=%h exp=%h", e, act0, exp_vec(0)); end
    end
    checks++;
    if (e0 != 5) begin failures++; $display("FAIL reset_lat0 got=%0d exp=5", e0); end
    checks++;
    if (e1 != 4) begin failures++; $display("FAIL reset_lat1 got=%0d exp=4", e1); end
    checks++;
    if ({p_at, q_at, n_at} !== {1'b1, 1'b1, 8'd1}) begin
      failures++; $display("FAIL reset_first_event got P=%b Q=%b N=%0d exp P=1 Q=1 N=1", p_at, q_at, n_at);
    end
    checks++;
    if (P0 !== 1'b0) begin failures++; $display("FAIL reset_pulse_width got P=%b exp 0", P0); end
  endtask

  task automatic test_glitch();
    bit y_seen;
    settle();
    y_seen = 0;
    A = 1'b1; tick(); tick();
    A = 1'b0;
    repeat (10) begin
      tick();
      if (Y0 === 1'b1 || P0 === 1'b1) y_seen = 1;
      checks++;
      if (act1 !== exp_vec(1)) begin failures++; $display("FAIL glitch1 got=%h exp=%h", act1, exp_vec(1)); end
    end
    checks++;
    if (y_seen) begin failures++; $display("FAIL glitch_y got=1 exp=0"); end
    checks++;
    if ({Q0, N0} !== 9'd0) begin failures++; $display("FAIL glitch_count got Q=%b N=%0d exp 0 0", Q0, N0); end
  endtask

  task automatic test_saturation();
    int n_tab[5] = '{1, 2, 3, 3, 3};
    settle();
    for (int k = 0; k < 5; k++) begin
      pulse(8, 8);
      checks++;
      if (N1 !== 2'(n_tab[k])) begin failures++; $display("FAIL sat_n k=%0d got=%0d exp=%0d", k, N1, n_tab[k]); end
      checks++;
      if (OVR1 !== (k >= 1)) begin failures++; $display("FAIL sat_ovr k=%0d got=%b exp=%b", k, OVR1, (k >= 1)); end
    end
    checks++;
    if (N0 !== 8'd5) begin failures++; $display("FAIL sat_n0 got=%0d exp=5", N0); end
  endtask

  task automatic test_ack_collision();
    A = 1'b1;
    repeat (4) tick();
    ACK = 1'b1; tick();
    ACK = 1'b0;
    checks++;
    if ({Y0, P0, Q0, N0, OVR0} !== {1'b1, 1'b1, 1'b1, 8'd1, 1'b0}) begin
      failures++; $display("FAIL ack_collision got Y=%b P=%b Q=%b N=%0d OVR=%b exp 1 1 1 1 0", Y0, P0, Q0, N0, OVR0);
    end
    checks++;
    if (act1 !== exp_vec(1)) begin failures++; $display("FAIL ack_collision1 got=%h exp=%h", act1, exp_vec(1)); end
    A = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_ack_plain();
    pulse(8, 8);
    pulse(8, 8);
    A = 1'b1; repeat (8) tick();
    checks++;
    if ({Q0, N0, OVR0} !== {1'b1, 8'd4, 1'b1}) begin
      failures++; $display("FAIL ack_pre got Q=%b N=%0d OVR=%b exp 1 4 1", Q0, N0, OVR0);
    end
    ACK = 1'b1; tick();
    ACK = 1'b0;
    checks++;
    if ({Y0, Q0, N0, OVR0} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
      failures++; $display("FAIL ack_plain got Y=%b Q=%b N=%0d OVR=%b exp 1 0 0 0", Y0, Q0, N0, OVR0);
    end
    A = 1'b0; repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int e0, e1;
    pulse(8, 10);
    A = 1'b1;
    repeat (4) tick();
    #1 CD = 1'b1;
    #1;
    checks++;
    if (act0 !== 12'h000) begin failures++; $display("FAIL mid_reset0 got=%h exp=000", act0); end
    checks++;
    if (act1 !== 12'h000) begin failures++; $display("FAIL mid_reset1 got=%h exp=000", act1); end
    tick(); tick();
    CD = 1'b0;
    e0 = 0; e1 = 0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e0 == 0 && Y0 === 1'b1) e0 = e;
      if (e1 == 0 && Y1 === 1'b1) e1 = e;
    end
    checks++;
    if (e0 != 5) begin failures++; $display("FAIL mid_reset_lat0 got=%0d exp=5", e0); end
    checks++;
    if (e1 != 4) begin failures++; $display("FAIL mid_reset_lat1 got=%0d exp=4", e1); end
    A = 1'b0; repeat (10) tick();
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        A    = ~A;
        hold = $urandom_range(8, 1);
      end
      hold--;
      ACK = ($urandom_range(7, 0) == 0);
      if ($urandom_range(499, 0) == 0) begin
        CD = 1'b1; tick(); CD = 1'b0;
      end
      tick();
      checks++;
      if (act0 !== exp_vec(0)) begin failures++; $display("FAIL random0 c=%0d got=%h exp=%h", c, act0, exp_vec(0)); end
      checks++;
      if (act1 !== exp_vec(1)) begin failures++; $display("FAIL random1 c=%0d got=%h exp=%h", c, act1, exp_vec(1)); end
    end
    ACK = 1'b0;
  endtask

  initial begin
    CD = 1'b1; A = 1'b1; ACK = 1'b0;
    test_reset();
    test_glitch();
    test_saturation();
    test_ack_collision();
    test_ack_plain();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
